// File: rtl/tiny_nn_cmd_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tiny_nn_cmd_sequencer
//
// Host-side job sequencer for tiny_nn_top. One job is serialised onto the
// 16-bit nn_data_o stream as:
//   command word {op, len}  ->  W weight words  ->  D data words
//   ->  Z FPZero drain cycles  ->  one DONE cycle.
// Weight and data words are pulled from a valid-qualified source stream. The
// datapath never stalls: a missing source word is replaced by FPZero and
// flagged on err_underrun_o. Result words from tiny_nn_top are exposed on
// res_data_o during the drain window, once RES_DELAY drain cycles have passed.
//
// Ports
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   start_i             launch a job (only looked at in IDLE)
//   op_i, len_i         command opcode / length, packed as {op, len}
//   weight_words_i      weight word count W (0 allowed)
//   data_words_i        data word count D (0 allowed)
//   drain_cycles_i      drain cycle count Z (0 allowed)
//   abort_i             abandon the running job, back to IDLE next cycle
//   src_req_o           a source word is consumed at this clock edge
//   src_valid_i         src_data_i holds a word
//   src_data_i          weight / data word
//   nn_data_o           registered stream into tiny_nn_top.data_i
//   nn_data_i           stream from tiny_nn_top.data_o
//   res_valid_o         res_data_o carries a result word
//   res_data_o          result word (nn_data_i passed straight through)
//   busy_o              a job is in progress
//   done_o              one-cycle pulse in the DONE cycle
//   err_underrun_o      sticky underrun flag, cleared by the next start
// ---------------------------------------------------------------------------
module tiny_nn_cmd_sequencer #(
  parameter int CNT_W     = 8,
  parameter int RES_DELAY = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [3:0]       op_i,
  input  logic [11:0]      len_i,
  input  logic [CNT_W-1:0] weight_words_i,
  input  logic [CNT_W-1:0] data_words_i,
  input  logic [CNT_W-1:0] drain_cycles_i,
  input  logic             abort_i,
  output logic             src_req_o,
  input  logic             src_valid_i,
  input  logic [15:0]      src_data_i,
  output logic [15:0]      nn_data_o,
  input  logic [15:0]      nn_data_i,
  output logic             res_valid_o,
  output logic [15:0]      res_data_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_underrun_o
);

  localparam logic [15:0]      FP_ZERO     = 16'h0000;
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [31:0]      RES_DELAY_U = RES_DELAY;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WGT,
    DAT,
    DRN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] w_q, d_q, z_q;
  logic [15:0]      nn_data_p1, nn_data_d;
  logic             err_q, err_d;
  logic             start_acc;
  logic             load_src;
  logic [CNT_W-1:0] drn_idx;

  // First non-empty phase among the ones still ahead; empty phases are
  // skipped with weights before data before drain.
  function automatic state_t phase_after(input logic has_w, input logic has_d,
                                         input logic has_z);
    state_t s;
    if (has_w)      s = WGT;
    else if (has_d) s = DAT;
    else if (has_z) s = DRN;
    else            s = DONE;
    return s;
  endfunction

  // Next-state and counter logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    start_acc = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = CMD;
        end
      end
      CMD: state_d = phase_after(w_q != '0, d_q != '0, z_q != '0);
      WGT: begin
        if (cnt_q == '0) state_d = phase_after(1'b0, d_q != '0, z_q != '0);
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      DAT: begin
        if (cnt_q == '0) state_d = phase_after(1'b0, 1'b0, z_q != '0);
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      DRN: begin
        if (cnt_q == '0) state_d = DONE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Down-counters hold count-1 on phase entry so a count of 2^CNT_W-1
    // never needs an extra bit.
    if (state_d != state_q) begin
      case (state_d)
        WGT:     cnt_d = w_q - CNT_ONE;
        DAT:     cnt_d = d_q - CNT_ONE;
        DRN:     cnt_d = z_q - CNT_ONE;
        default: cnt_d = '0;
      endcase
    end

    // Abort overrides everything except a start taken in IDLE.
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // A source word is consumed whenever the next visible slot is a weight or
  // data slot; the word lands in nn_data_o at that same edge.
  assign load_src = (state_d == WGT) || (state_d == DAT);

  always_comb begin
    nn_data_d = FP_ZERO;
    err_d     = err_q;
    if (start_acc) begin
      nn_data_d = {op_i, len_i};
      err_d     = 1'b0;
    end else if (load_src) begin
      if (src_valid_i) begin
        nn_data_d = src_data_i;
      end else begin
        nn_data_d = FP_ZERO;
        err_d     = 1'b1;
      end
    end
  end

  // Stage p1: state, counters, latched job, output word
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      w_q        <= '0;
      d_q        <= '0;
      z_q        <= '0;
      nn_data_p1 <= FP_ZERO;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      nn_data_p1 <= nn_data_d;
      err_q      <= err_d;
      if (start_acc) begin
        w_q <= weight_words_i;
        d_q <= data_words_i;
        z_q <= drain_cycles_i;
      end
    end
  end

  // Drain index counts up from 0; derived from the down-counter so no
  // second counter is needed. cnt_q <= z_q-1 inside DRN, so no underflow.
  assign drn_idx = z_q - CNT_ONE - cnt_q;

  assign res_valid_o    = (state_q == DRN) &&
                          ({{(32-CNT_W){1'b0}}, drn_idx} >= RES_DELAY_U);
  assign res_data_o     = nn_data_i;
  assign src_req_o      = load_src;
  assign nn_data_o      = nn_data_p1;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign err_underrun_o = err_q;

endmodule

// File: tb/tb_tiny_nn_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_tiny_nn_cmd_sequencer;
  localparam int CNT_W = 8;
  localparam int RES_DELAY = 4;
  localparam logic [3:0] CMD_OP_CONVOLVE = 4'h3;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             start_i = 1'b0;
  logic [3:0]       op_i = '0;
  logic [11:0]      len_i = '0;
  logic [CNT_W-1:0] weight_words_i = '0;
  logic [CNT_W-1:0] data_words_i = '0;
  logic [CNT_W-1:0] drain_cycles_i = '0;
  logic             abort_i = 1'b0;
  logic             src_req_o;
  logic             src_valid_i = 1'b0;
  logic [15:0]      src_data_i = '0;
  logic [15:0]      nn_data_o;
  logic [15:0]      nn_data_i = '0;
  logic             res_valid_o;
  logic [15:0]      res_data_o;
  logic             busy_o;
  logic             done_o;
  logic             err_underrun_o;

  always #5 clk_i = ~clk_i;

  tiny_nn_cmd_sequencer #(.CNT_W(CNT_W), .RES_DELAY(RES_DELAY)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i), .len_i(len_i),
    .weight_words_i(weight_words_i), .data_words_i(data_words_i),
    .drain_cycles_i(drain_cycles_i), .abort_i(abort_i), .src_req_o(src_req_o),
    .src_valid_i(src_valid_i), .src_data_i(src_data_i), .nn_data_o(nn_data_o),
    .nn_data_i(nn_data_i), .res_valid_o(res_valid_o), .res_data_o(res_data_o),
    .busy_o(busy_o), .done_o(done_o), .err_underrun_o(err_underrun_o)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Job-timeline model: a job occupies cycle positions 1..N after its start
  // edge, N = W+D+Z+2. Position 1 is the command, 2..W+D+1 are source slots,
  // W+D+2..W+D+Z+1 are drain, N is done.
  bit          m_act = 0;
  int          m_pos = 0, m_w = 0, m_d = 0, m_z = 0;
  logic [15:0] m_nn = '0;
  bit          m_err = 0;

  always @(negedge clk_i) begin
    int n;
    bit e_done, e_res, e_req;
    if (!rst_ni) begin
      m_act = 0; m_nn = '0; m_err = 0;
    end
    n      = m_w + m_d + m_z + 2;
    e_done = m_act && (m_pos == n);
    e_res  = m_act && (m_pos >= m_w + m_d + 2) && (m_pos <= m_w + m_d + m_z + 1) &&
             (m_pos - (m_w + m_d + 2) >= RES_DELAY);
    e_req  = m_act && !abort_i && (m_pos + 1 <= m_w + m_d + 1);
    chk("nn_data", nn_data_o, m_nn);
    chk("busy", busy_o, m_act);
    chk("done", done_o, e_done);
    chk("res_valid", res_valid_o, e_res);
    chk("src_req", src_req_o, e_req);
    chk("err_underrun", err_underrun_o, m_err);
    chk("res_data", res_data_o, nn_data_i);
    // outcome of the coming edge
    if (rst_ni) begin
      if (m_act) begin
        if (abort_i || m_pos == n) begin
          m_act = 0; m_nn = '0;
        end else begin
          m_pos++;
          if (m_pos <= m_w + m_d + 1) begin
            if (src_valid_i) m_nn = src_data_i;
            else begin m_nn = '0; m_err = 1; end
          end else m_nn = '0;
        end
      end else if (start_i) begin
        m_act = 1; m_pos = 1;
        m_w = int'(weight_words_i); m_d = int'(data_words_i); m_z = int'(drain_cycles_i);
        m_nn = {op_i, len_i}; m_err = 0;
      end else m_nn = '0;
    end
  end

  // One job: start at cycle 0, then ncyc cycles. Source word k is offered in
  // cycle k+1; weights carry wval, data words are an index-derived image.
  task automatic run_job(input logic [3:0] op, input logic [11:0] len,
                         input int w, input int d, input int z, input logic [15:0] wval,
                         input int drop_k, input int abort_c, input int bstart_c,
                         input int rst_c, input int ncyc,
                         output int done_c, output int busy_n, output int res_n,
                         output logic [15:0] cmd_seen);
    done_c = 0; busy_n = 0; res_n = 0; cmd_seen = '0;
    @(posedge clk_i); #1;
    start_i = 1'b1; abort_i = 1'b0; op_i = op; len_i = len;
    weight_words_i = CNT_W'(w); data_words_i = CNT_W'(d); drain_cycles_i = CNT_W'(z);
    src_valid_i = 1'b0; nn_data_i = '0;
    for (int c = 1; c <= ncyc; c++) begin
      int k;
      @(posedge clk_i); #1;
      k = c - 1;
      start_i = (c == bstart_c);
      abort_i = (c == abort_c);
      rst_ni  = (c != rst_c);
      op_i = 4'($urandom); len_i = 12'($urandom);
      weight_words_i = CNT_W'($urandom_range(1, 5));
      data_words_i   = CNT_W'($urandom_range(1, 5));
      drain_cycles_i = CNT_W'($urandom_range(1, 5));
      src_valid_i = (k != drop_k);
      if (k < w)          src_data_i = wval;
      else if (k < w + d) src_data_i = 16'h4100 + 16'((k - w) * 3);
      else                src_data_i = 16'($urandom);
      nn_data_i = 16'(c);
      @(negedge clk_i);
      if (c == 1) cmd_seen = nn_data_o;
      if (busy_o) busy_n++;
      if (res_valid_o) res_n++;
      if (done_o && done_c == 0) done_c = c;
    end
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0; rst_ni = 1'b1; src_valid_i = 1'b0;
  endtask

  initial begin
    int dc, bn, rn;
    logic [15:0] cw;

    @(negedge clk_i);
    chk("rst_busy", busy_o, 0);
    chk("rst_nn_data", nn_data_o, 16'h0000);
    chk("rst_err", err_underrun_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Convolve job, plus a start pulse while busy
    run_job(CMD_OP_CONVOLVE, 12'd32, 8, 16, 70, 16'h3f00, -1, 0, 40, 0, 98, dc, bn, rn, cw);
    chk("conv_cmd", cw, 16'h3020);
    chk("conv_done_cycle", dc, 96);
    chk("conv_busy_cycles", bn, 96);
    chk("conv_res_cycles", rn, 66);
    chk("conv_err", err_underrun_o, 0);

    // Zero-length phases
    run_job(4'h1, 12'd5, 0, 3, 0, 16'h1111, -1, 0, 0, 0, 7, dc, bn, rn, cw);
    chk("zero_busy_cycles", bn, 5);
    chk("zero_done_cycle", dc, 5);
    chk("zero_res_cycles", rn, 0);

    // Underrun on the 2nd data word
    run_job(4'h2, 12'd9, 2, 4, 3, 16'h2222, 3, 0, 0, 0, 13, dc, bn, rn, cw);
    chk("underrun_done_cycle", dc, 11);
    chk("underrun_err_sticky", err_underrun_o, 1);

    // Result window
    run_job(4'h4, 12'd10, 2, 2, 10, 16'h3333, -1, 0, 0, 0, 18, dc, bn, rn, cw);
    chk("window_res_cycles", rn, 6);
    chk("window_done_cycle", dc, 16);
    chk("window_err_cleared", err_underrun_o, 0);

    // Abort in the data phase with a start pulse while busy
    run_job(4'h5, 12'd7, 2, 10, 5, 16'h5555, -1, 7, 5, 0, 20, dc, bn, rn, cw);
    chk("abort_done_cycle", dc, 0);
    chk("abort_busy_cycles", bn, 7);
    run_job(4'h6, 12'd3, 1, 2, 5, 16'h6666, -1, 0, 0, 0, 12, dc, bn, rn, cw);
    chk("post_abort_done_cycle", dc, 10);

    // Async reset during drain
    run_job(4'h7, 12'd4, 2, 2, 8, 16'h7777, 2, 0, 0, 9, 18, dc, bn, rn, cw);
    chk("reset_done_cycle", dc, 0);
    chk("reset_busy_cycles", bn, 8);
    chk("reset_err_cleared", err_underrun_o, 0);
    run_job(4'h8, 12'd6, 3, 3, 6, 16'h8888, -1, 0, 0, 0, 16, dc, bn, rn, cw);
    chk("post_reset_done_cycle", dc, 14);

    // Maximum counts must not wrap
    run_job(4'h9, 12'hfff, 255, 0, 255, 16'h9999, -1, 0, 0, 0, 514, dc, bn, rn, cw);
    chk("max_done_cycle", dc, 512);
    chk("max_res_cycles", rn, 251);
    chk("max_cmd", cw, 16'h9fff);

    // Randomised traffic
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk_i); #1;
      start_i        = ($urandom_range(0, 5) == 0);
      abort_i        = ($urandom_range(0, 49) == 0);
      rst_ni         = ($urandom_range(0, 499) != 0);
      op_i           = 4'($urandom);
      len_i          = 12'($urandom);
      weight_words_i = CNT_W'($urandom_range(0, 9));
      data_words_i   = CNT_W'($urandom_range(0, 9));
      drain_cycles_i = CNT_W'($urandom_range(0, 9));
      src_valid_i    = ($urandom_range(0, 7) != 0);
      src_data_i     = 16'($urandom);
      nn_data_i      = 16'($urandom);
    end
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0; rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tiny_nn_cmd_sequencer.md
Name: tiny_nn_cmd_sequencer

Overview:
Host-side job sequencer that drives the 16-bit `data_i` stream of `tiny_nn_top` and collects its output. It serialises one job as: command word, weight/parameter words, data words, then FPZero drain cycles. Weight and data words are pulled from a source stream. Result words are presented during the drain window. It replaces hand-timed stimulus so that jobs can be issued back-to-back by a host or CPU shim.

Parameters:
- CNT_W, 8, width of the weight, data and drain count inputs and their internal counters.
- RES_DELAY, 4, number of drain cycles after the last data word before `res_valid_o` may assert.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- start_i  in  1  launch a job. Sampled only in IDLE.
- op_i  in  4  opcode (tiny_nn_pkg CmdOp*). Placed in `cmd[15:12]`.
- len_i  in  12  command length field. Placed in `cmd[11:0]`.
- weight_words_i  in  CNT_W  number of weight words (0 allowed).
- data_words_i  in  CNT_W  number of data words (0 allowed).
- drain_cycles_i  in  CNT_W  number of FPZero drain cycles (0 allowed).
- abort_i  in  1  abandon the current job.
- src_req_o  out  1  a source word is consumed at this clock edge.
- src_valid_i  in  1  `src_data_i` is valid.
- src_data_i  in  16  weight/data word.
- nn_data_o  out  16  to `tiny_nn_top.data_i`. Registered.
- nn_data_i  in  16  from `tiny_nn_top.data_o`.
- res_valid_o  out  1  `res_data_o` is a result word.
- res_data_o  out  16  result word; equals `nn_data_i`, combinational.
- busy_o  out  1  a job is in progress (state != IDLE).
- done_o  out  1  one-cycle pulse when a job completes.
- err_underrun_o  out  1  sticky underrun flag; cleared by the next accepted `start_i`.

Behaviour:
- Reset values: `nn_data_o` = FPZero; `busy_o`, `done_o`, `res_valid_o`, `src_req_o`, `err_underrun_o` = 0; state = IDLE; all counters = 0.
- States: IDLE, CMD, WGT, DAT, DRN, DONE.
- IDLE: `nn_data_o` <= FPZero every cycle.
  - On `start_i`: latch all job inputs, clear `err_underrun_o`, go to CMD.
- Output timing: `nn_data_o` is updated at every edge. The value shown below for a state is the value visible during the cycle that state occupies.
- CMD, 1 cycle: `nn_data_o` = {op, len}.
  - Next state is WGT if W>0, else DAT if D>0, else DRN if Z>0, else DONE.
- WGT, W cycles, then DAT, D cycles:
  - `src_req_o` is high in the cycle before each word appears, i.e. at the edge that loads `nn_data_o`.
  - If `src_valid_i`=1 at that edge: `nn_data_o` <= `src_data_i`.
  - Otherwise: `nn_data_o` <= FPZero and `err_underrun_o` <= 1. The counter still advances; the datapath has no stall.
  - Empty phases are skipped using the same priority as CMD.
- DRN, Z cycles: `nn_data_o` = FPZero.
  - `res_valid_o` = 1 on drain cycles whose index is >= RES_DELAY, counting from 0.
  - If Z <= RES_DELAY, `res_valid_o` never asserts.
- DONE, 1 cycle: `done_o` = 1, `nn_data_o` = FPZero, then go to IDLE.
  - `start_i` in the DONE cycle is ignored. Minimum gap between jobs is 1 IDLE cycle.
- Latency: with `start_i` high at edge t, the cmd word is visible in cycle t+1 and the first weight word in cycle t+2. Total busy cycles = 1 + W + D + Z + 1.
- Counters: down-counters loaded with count−1 on phase entry; the phase exits when the counter reaches 0. The maximum count 2^CNT_W−1 must not wrap.
- `start_i` while busy: ignored, with no effect on the job inputs.
- `abort_i` (priority over all other events, any non-IDLE state):
  - next state IDLE, `nn_data_o` <= FPZero, `src_req_o` low in that cycle;
  - no `done_o`; `err_underrun_o` is preserved.
- `abort_i` in IDLE together with `start_i`: start wins.
- Async reset mid-job: immediately return to reset values. No `done_o`.

Test Plan:
- Convolve job: op=CmdOpConvolve, len=32, W=8 (src 16'h3f00 each), D=16 (16-word image), Z=70. Required: cmd word {CmdOpConvolve, 12'd32} at cycle t+1; 8×3f00 then the image words in order; 70 FPZero cycles; `done_o` at cycle t+96; `err_underrun_o`=0.
- Zero-length phases: W=0, D=3, Z=0. Required: cmd, then 3 data words, then DONE; busy for exactly 5 cycles; `res_valid_o` never asserts.
- Underrun: drop `src_valid_i` for the 2nd data word. Required: FPZero in that slot, later words not shifted, `err_underrun_o`=1 until the next start.
- Result window: RES_DELAY=4, Z=10, `nn_data_i` ramps 1,2,3,… per cycle. Required: `res_valid_o` high for exactly 6 cycles, with `res_data_o` = `nn_data_i` in each.
- Abort in the middle of the data phase, plus `start_i` pulsed while busy. Required: return to IDLE next cycle, no `done_o`, the busy-time start ignored; a new job then runs cleanly.
- Async reset asserted during DRN. Required: all outputs immediately at reset values; a subsequent job is correct.
